// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer: FSM states,
// i_data_type encodings, base byte masks and the misaligned-split rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC0 = 2'b01,
    ACC1 = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;

  localparam logic [3:0] MASK_WORD = 4'b1111;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_BYTE = 4'b0001;

  // Encoding 2'b11 is treated as a word everywhere.
  function automatic logic [3:0] base_mask(input logic [1:0] dtype);
    case (dtype)
      DT_BYTE: base_mask = MASK_BYTE;
      DT_HALF: base_mask = MASK_HALF;
      default: base_mask = MASK_WORD;
    endcase
  endfunction

  function automatic logic needs_split(input logic [1:0] dtype, input logic [1:0] offset);
    case (dtype)
      DT_BYTE: needs_split = 1'b0;
      DT_HALF: needs_split = (offset == 2'd3);
      default: needs_split = (offset != 2'd0);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte masks, store-data shift and load-data
// merge/extend across the two words of a possibly misaligned access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  dtype,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic [7:0]  mask8,
  output logic [63:0] wdata64,
  output logic [31:0] ld_data
);

  logic [4:0]  shamt;
  logic [63:0] rdata64;

  assign shamt   = {offset, 3'b000};
  assign mask8   = {4'b0000, base_mask(dtype)} << offset;
  assign wdata64 = {32'b0, wdata} << shamt;
  assign rdata64 = {rdata1, rdata0} >> shamt;

  always_comb begin
    ld_data = rdata64[31:0];
    case (dtype)
      DT_BYTE: ld_data = is_unsigned ? {24'b0, rdata64[7:0]}
                                     : {{24{rdata64[7]}}, rdata64[7:0]};
      DT_HALF: ld_data = is_unsigned ? {16'b0, rdata64[15:0]}
                                     : {{16{rdata64[15]}}, rdata64[15:0]};
      default: ld_data = rdata64[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer FSM driving a single req/ack data-memory port.
// Optional ack timeout enabled with `define LSU_TIMEOUT_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_lsu_req,
  input  logic              i_lsu_wren,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [1:0]        i_data_type,
  input  logic              i_unsigned,
  output logic              o_stall,
  output logic              o_done,
  output logic [31:0]       o_ld_data,
  output logic              o_mem_req,
  output logic              o_mem_wren,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_bus_err
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        dtype_q, dtype_d;
  logic              uns_q, uns_d;
  logic              wren_q, wren_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;

  logic              in_acc;
  logic              timed_out;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        mask8;
  logic [63:0]       wdata64;
  logic [31:0]       ld_data;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  assign timed_out = err_q;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYC == 0);
  assign timed_out      = 1'b0;
`endif

  lsu_align u_align (
    .dtype       (dtype_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata0      (rdata0_q),
    .rdata1      (rdata1_q),
    .mask8       (mask8),
    .wdata64     (wdata64),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dtype_d  = dtype_q;
    uns_d    = uns_q;
    wren_d   = wren_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_lsu_req) begin
          addr_d   = i_addr;
          wdata_d  = i_wdata;
          dtype_d  = i_data_type;
          uns_d    = i_unsigned;
          wren_d   = i_lsu_wren;
          rdata0_d = '0;
          rdata1_d = '0;
          state_d  = ACC0;
`ifdef LSU_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end
      end
      ACC0: begin
        if (i_mem_ack) begin
          rdata0_d = i_mem_rdata;
          state_d  = needs_split(dtype_q, addr_q[1:0]) ? ACC1 : DONE;
        end
      end
      ACC1: begin
        if (i_mem_ack) begin
          rdata1_d = i_mem_rdata;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef LSU_TIMEOUT_EN
    // Abandon the whole access once the ack wait hits the limit.
    if ((state_q == ACC0 || state_q == ACC1) && !i_mem_ack) begin
      if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
        cnt_d   = '0;
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      dtype_q  <= '0;
      uns_q    <= 1'b0;
      wren_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dtype_q  <= dtype_d;
      uns_q    <= uns_d;
      wren_q   <= wren_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Memory-side outputs are decoded from the state flop so reset drops them at once.
  assign in_acc      = (state_q == ACC0) || (state_q == ACC1);
  assign word_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_mem_req   = in_acc;
  assign o_mem_wren  = in_acc && wren_q;
  assign o_mem_addr  = (state_q == ACC0) ? word_addr :
                       (state_q == ACC1) ? word_addr + ADDR_W'(4) : '0;
  assign o_mem_bmask = (state_q == ACC0) ? mask8[3:0] :
                       (state_q == ACC1) ? mask8[7:4] : 4'b0000;
  assign o_mem_wdata = !o_mem_wren        ? 32'b0 :
                       (state_q == ACC0)  ? wdata64[31:0] : wdata64[63:32];

  assign o_stall     = ((state_q == IDLE) && i_lsu_req) || in_acc;
  assign o_done      = (state_q == DONE);
  assign o_ld_data   = (o_done && !wren_q && !timed_out) ? ld_data : 32'b0;
  assign o_bus_err   = o_done && timed_out;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed load/store vectors push expected
// memory accesses and completions; a negedge monitor acts as memory and checks.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_lsu_req = 1'b0;
  logic        i_lsu_wren = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [1:0]  i_data_type = '0;
  logic        i_unsigned = 1'b0;
  logic        o_stall, o_done, o_mem_req, o_mem_wren, o_bus_err;
  logic [31:0] o_ld_data, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(255)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_lsu_req   (i_lsu_req),
    .i_lsu_wren  (i_lsu_wren),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_data_type (i_data_type),
    .i_unsigned  (i_unsigned),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_ld_data   (o_ld_data),
    .o_mem_req   (o_mem_req),
    .o_mem_wren  (o_mem_wren),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_bmask (o_mem_bmask),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_bus_err   (o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        wren;
  } acc_t;

  typedef struct {
    logic [31:0] ld;
    int          due;
  } done_t;

  acc_t        exp_acc[$];
  done_t       exp_done[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_idx = 0;
  int          wait_cnt = 0;
  int          dly0 = 0;
  int          dly1 = 0;
  logic [31:0] rd0 = '0;
  logic [31:0] rd1 = '0;
  string       cur_test = "reset";

  always @(posedge i_clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s/%s: got 0x%08h expected 0x%08h", cur_test, name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s/%s: event not as expected", cur_test, name);
  endtask

  // Memory responder and scoreboard monitor.
  always @(negedge i_clk) begin
    acc_t  a;
    done_t d;
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'hDEAD_0000;
    if (!i_reset) begin
      if (o_mem_req) begin
        checkOutput("stall_in_acc", {31'b0, o_stall}, 32'd1);
        if (exp_acc.size() == 0) begin
          failNow("unexpected_req");
        end else begin
          a = exp_acc[0];
          checkOutput("mem_addr", o_mem_addr, a.addr);
          checkOutput("mem_bmask", {28'b0, o_mem_bmask}, {28'b0, a.mask});
          checkOutput("mem_wdata", o_mem_wdata, a.wdata);
          checkOutput("mem_wren", {31'b0, o_mem_wren}, {31'b0, a.wren});
          if (wait_cnt >= ((acc_idx == 0) ? dly0 : dly1)) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = (acc_idx == 0) ? rd0 : rd1;
            void'(exp_acc.pop_front());
            acc_idx++;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
      if (o_done) begin
        checkOutput("stall_in_done", {31'b0, o_stall}, 32'd0);
        checkOutput("bus_err", {31'b0, o_bus_err}, 32'd0);
        if (exp_done.size() == 0) begin
          failNow("unexpected_done");
        end else begin
          d = exp_done.pop_front();
          checkOutput("ld_data", o_ld_data, d.ld);
          checkOutput("done_cycle", cyc, d.due);
        end
      end
    end
  end

  task automatic waitDone();
    int n = 0;
    while (exp_done.size() != 0 && n < 300) begin
      @(posedge i_clk);
      n++;
    end
    if (exp_done.size() != 0) begin
      failNow("done_timeout");
      exp_done.delete();
      exp_acc.delete();
    end
    checkOutput("acc_left", exp_acc.size(), 32'd0);
    repeat (3) @(posedge i_clk);
  endtask

  task automatic applyStimulus(
    input string name, input logic wren, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [1:0] dt, input logic uns, input logic [31:0] r0, input logic [31:0] r1,
    input int d0, input int d1, input int nacc,
    input logic [31:0] a0, input logic [3:0] m0, input logic [31:0] w0,
    input logic [31:0] a1, input logic [3:0] m1, input logic [31:0] w1,
    input logic [31:0] ld, input int lat, input bit wait_done);
    @(posedge i_clk);
    #1;
    cur_test = name;
    rd0 = r0; rd1 = r1; dly0 = d0; dly1 = d1;
    acc_idx = 0; wait_cnt = 0;
    exp_acc.push_back('{addr: a0, mask: m0, wdata: w0, wren: wren});
    if (nacc == 2) exp_acc.push_back('{addr: a1, mask: m1, wdata: w1, wren: wren});
    exp_done.push_back('{ld: ld, due: cyc + lat});
    i_lsu_wren = wren; i_addr = addr; i_wdata = wdata;
    i_data_type = dt; i_unsigned = uns; i_lsu_req = 1'b1;
    #1;
    checkOutput("stall_accept", {31'b0, o_stall}, 32'd1);
    @(posedge i_clk);
    #1;
    i_lsu_req = 1'b0;
    i_addr = 32'hFFFF_FFF1; i_wdata = 32'h1234_5678;
    i_data_type = ~dt; i_unsigned = ~uns; i_lsu_wren = ~wren;
    if (wait_done) waitDone();
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst_stall", {31'b0, o_stall}, 32'd0);
    checkOutput("rst_done", {31'b0, o_done}, 32'd0);
    checkOutput("rst_mem_req", {31'b0, o_mem_req}, 32'd0);
    checkOutput("rst_mem_addr", o_mem_addr, 32'd0);
    checkOutput("rst_bmask", {28'b0, o_mem_bmask}, 32'd0);
    checkOutput("rst_ld_data", o_ld_data, 32'd0);
    checkOutput("rst_bus_err", {31'b0, o_bus_err}, 32'd0);
    i_reset = 1'b0;

    //            name     wr    addr          wdata         dt       u  rd0           rd1           d0 d1 n  a0            m0       w0            a1            m1       w1            ld            lat
    applyStimulus("lb",    1'b0, 32'h103,      32'h0,        DT_BYTE, 0, 32'h80FF_FFFF, 32'h0,        0, 0, 1, 32'h100,      4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_FF80, 2, 1);
    applyStimulus("lbu",   1'b0, 32'h103,      32'h0,        DT_BYTE, 1, 32'h80FF_FFFF, 32'h0,        0, 0, 1, 32'h100,      4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_0080, 2, 1);
    applyStimulus("sw_split", 1'b1, 32'h202,   32'hDEAD_BEEF, DT_WORD, 0, 32'h0,        32'h0,        0, 0, 2, 32'h200,      4'b1100, 32'hBEEF_0000, 32'h204,      4'b0011, 32'h0000_DEAD, 32'h0,        3, 1);
    applyStimulus("lh_split", 1'b0, 32'h3,     32'h0,        DT_HALF, 0, 32'hAB00_0000, 32'h0000_00CD, 0, 0, 2, 32'h0,        4'b1000, 32'h0,        32'h4,        4'b0001, 32'h0,        32'hFFFF_CDAB, 3, 1);
    applyStimulus("lw_slow", 1'b0, 32'h40,     32'h0,        DT_WORD, 0, 32'h1234_5678, 32'h0,        5, 0, 1, 32'h40,       4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h1234_5678, 7, 1);
    applyStimulus("lhu",   1'b0, 32'h106,      32'h0,        DT_HALF, 1, 32'h8001_0000, 32'h0,        0, 0, 1, 32'h104,      4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_8001, 2, 1);
    applyStimulus("sh",    1'b1, 32'h105,      32'h0000_A5C3, DT_HALF, 0, 32'h0,        32'h0,        1, 0, 1, 32'h104,      4'b0110, 32'h00A5_C300, 32'h0,        4'b0000, 32'h0,        32'h0,        3, 1);
    applyStimulus("sb",    1'b1, 32'h7,        32'h0000_005A, DT_BYTE, 0, 32'h0,        32'h0,        0, 0, 1, 32'h4,        4'b1000, 32'h5A00_0000, 32'h0,        4'b0000, 32'h0,        32'h0,        2, 1);
    applyStimulus("lw_mis", 1'b0, 32'h1,       32'h0,        DT_WORD, 0, 32'h4433_2211, 32'h8877_6655, 0, 2, 2, 32'h0,        4'b1110, 32'h0,        32'h4,        4'b0001, 32'h0,        32'h5544_3322, 5, 1);
    applyStimulus("lw_t11", 1'b0, 32'h10,      32'h0,        2'b11,   0, 32'hCAFE_F00D, 32'h0,        0, 0, 1, 32'h10,       4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hCAFE_F00D, 2, 1);

    // Reset while the second half of a split store is waiting for ack.
    applyStimulus("rst_acc1", 1'b1, 32'h202,   32'hDEAD_BEEF, DT_WORD, 0, 32'h0,        32'h0,        0, 20, 2, 32'h200,     4'b1100, 32'hBEEF_0000, 32'h204,      4'b0011, 32'h0000_DEAD, 32'h0,        3, 0);
    begin
      int n = 0;
      while (acc_idx != 1 && n < 50) begin
        @(posedge i_clk);
        n++;
      end
    end
    @(posedge i_clk);
    #2;
    checkOutput("acc1_req", {31'b0, o_mem_req}, 32'd1);
    checkOutput("acc1_addr", o_mem_addr, 32'h204);
    i_reset = 1'b1;
    #1;
    checkOutput("rst_req_drop", {31'b0, o_mem_req}, 32'd0);
    checkOutput("rst_stall_drop", {31'b0, o_stall}, 32'd0);
    checkOutput("rst_bmask_drop", {28'b0, o_mem_bmask}, 32'd0);
    exp_acc.delete();
    exp_done.delete();
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("post_rst_idle", {31'b0, o_mem_req}, 32'd0);

    applyStimulus("lw_after_rst", 1'b0, 32'h20, 32'h0,       DT_WORD, 0, 32'h0BAD_F00D, 32'h0,        0, 0, 1, 32'h20,       4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0BAD_F00D, 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
